// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DW_DEF    = 8;
    localparam int VW_DEF    = 4;
    localparam int CNT_W_DEF = $clog2(DW_DEF);

    // Bit-counter width; never narrower than one bit even for tiny dividends.
    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int VW = VW_DEF
) (
    input  logic [VW:0]   p_in,
    input  logic          d_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   p_out,
    output logic          q_bit
);

    logic [VW+1:0] w_shifted;
    logic [VW+1:0] w_divisor_ext;

    // One spare bit on top keeps the compare exact even if p_in ever reached 2**VW.
    assign w_shifted     = {p_in, d_bit};
    assign w_divisor_ext = {2'b00, divisor};
    assign q_bit         = (w_shifted >= w_divisor_ext);
    assign p_out         = q_bit ? (VW+1)'(w_shifted - w_divisor_ext) : w_shifted[VW:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
//
// state | meaning
// IDLE  | waiting for start; results from the last request held
// RUN   | iterating, one quotient bit per cycle, busy high
// DONE  | one-cycle done pulse; a new start is accepted here too
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = cnt_width(DW);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_d;
    logic [VW-1:0] r_v;
    logic [VW:0]   r_p;

    logic [VW:0]   w_p_out;
    logic          w_q_bit;

    div_step #(.VW(VW)) u_step (
        .p_in    (r_p),
        .d_bit   (r_d[DW-1]),
        .divisor (r_v),
        .p_out   (w_p_out),
        .q_bit   (w_q_bit)
    );

    // r_d shifts dividend bits out of the top while quotient bits enter at the
    // bottom, so after DW steps it holds the complete quotient.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_d         <= '0;
            r_v         <= '0;
            r_p         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_d         <= dividend;
                        r_v         <= divisor;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            r_state     <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            busy    <= 1'b1;
                            r_cnt   <= CW'(DW - 1);
                            r_p     <= '0;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_p <= w_p_out;
                    r_d <= {r_d[DW-2:0], w_q_bit};
                    if (r_cnt == '0) begin
                        r_state   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= {r_d[DW-2:0], w_q_bit};
                        remainder <= w_p_out[VW-1:0];
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus a randomized exhaustive sweep.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_divider #(.DW(8), .VW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference: plain integer division; divide-by-zero yields all ones, remainder 0.
    function automatic void ref_div(input int a, input int b, output int q, output int r);
        if (b == 0) begin
            q = 255;
            r = 0;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called at a negedge; the request is sampled at the next rising edge.
    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    // Samples each following cycle at the negedge until done or the budget expires.
    task automatic track(input int max_cyc, output int done_cyc, output int busy_cnt,
                         output bit busy_ok, output bit hold_ok);
        logic [7:0] q0;
        logic [3:0] r0;
        q0 = '0;
        r0 = '0;
        done_cyc = -1;
        busy_cnt = 0;
        busy_ok  = 1'b1;
        hold_ok  = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (c == 1) begin
                q0 = quotient;
                r0 = remainder;
            end
            if (busy === 1'b1) begin
                busy_cnt++;
                if (busy_cnt != c) busy_ok = 1'b0;
                if (quotient !== q0 || remainder !== r0) hold_ok = 1'b0;
            end
            if (done === 1'b1) begin
                if (busy !== 1'b0) busy_ok = 1'b0;
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", quotient); end
        checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL reset_r: got %0d want 0", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int dc, bc;
        bit bok, hok;
        issue(8'd200, 4'd7);
        track(20, dc, bc, bok, hok);
        checks++; if (dc != 9) begin errors++; $display("FAIL basic_done_cycle: got %0d want 9", dc); end
        checks++; if (bc != 8 || !bok) begin errors++; $display("FAIL basic_busy: cycles %0d contiguous %0d want 8 1", bc, bok); end
        checks++; if (!hok) begin errors++; $display("FAIL basic_hold: outputs changed while busy"); end
        checks++; if (quotient !== 8'd28 || remainder !== 4'd4 || div_by_zero !== 1'b0) begin
            errors++; $display("FAIL basic_result: got q=%0d r=%0d dbz=%b want 28 4 0", quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_pulse: done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_zero();
        int dc, bc;
        bit bok, hok;
        issue(8'd100, 4'd0);
        track(6, dc, bc, bok, hok);
        checks++; if (dc != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d want 1", dc); end
        checks++; if (bc != 0) begin errors++; $display("FAIL zero_busy: got %0d busy cycles want 0", bc); end
        checks++; if (quotient !== 8'hFF || remainder !== 4'd0 || div_by_zero !== 1'b1) begin
            errors++; $display("FAIL zero_result: got q=%0h r=%0d dbz=%b want ff 0 1", quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || div_by_zero !== 1'b1) begin
            errors++; $display("FAIL zero_after: done=%b dbz=%b want 0 1", done, div_by_zero);
        end
    endtask

    task automatic test_boundary();
        int dc, bc;
        bit bok, hok;
        int tab [3][4] = '{'{255, 15, 17, 0}, '{5, 9, 0, 5}, '{0, 3, 0, 0}};
        for (int i = 0; i < 3; i++) begin
            issue(8'(tab[i][0]), 4'(tab[i][1]));
            track(20, dc, bc, bok, hok);
            checks++;
            if (dc != 9 || quotient !== 8'(tab[i][2]) || remainder !== 4'(tab[i][3]) || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL boundary_%0d_%0d: got cyc=%0d q=%0d r=%0d dbz=%b want 9 %0d %0d 0",
                         tab[i][0], tab[i][1], dc, quotient, remainder, div_by_zero, tab[i][2], tab[i][3]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignored();
        int dc, bc;
        bit bok, hok;
        issue(8'd200, 4'd7);
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 4'd5;
        @(posedge clk);
        #1 start = 1'b0;
        track(12, dc, bc, bok, hok);
        checks++; if (dc != 6 || bc != 5) begin errors++; $display("FAIL ignored_timing: got done %0d busy %0d want 6 5", dc, bc); end
        checks++; if (quotient !== 8'd28 || remainder !== 4'd4) begin
            errors++; $display("FAIL ignored_result: got q=%0d r=%0d want 28 4", quotient, remainder);
        end
        track(15, dc, bc, bok, hok);
        checks++; if (dc != -1 || bc != 0) begin errors++; $display("FAIL ignored_queued: extra done at %0d busy %0d want none", dc, bc); end
    endtask

    task automatic test_back_to_back();
        int dc, bc;
        bit bok, hok;
        issue(8'd200, 4'd7);
        track(20, dc, bc, bok, hok);
        checks++; if (dc != 9 || quotient !== 8'd28 || remainder !== 4'd4) begin
            errors++; $display("FAIL b2b_first: got cyc=%0d q=%0d r=%0d want 9 28 4", dc, quotient, remainder);
        end
        issue(8'd99, 4'd10);
        track(20, dc, bc, bok, hok);
        checks++; if (dc != 9 || bc != 8 || !bok) begin
            errors++; $display("FAIL b2b_timing: got done %0d busy %0d contiguous %0d want 9 8 1", dc, bc, bok);
        end
        checks++; if (quotient !== 8'd9 || remainder !== 4'd9 || !hok) begin
            errors++; $display("FAIL b2b_second: got q=%0d r=%0d hold=%0d want 9 9 1", quotient, remainder, hok);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dc, bc;
        bit bok, hok;
        issue(8'd200, 4'd7);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
                               busy, done, quotient, remainder, div_by_zero);
        end
        track(15, dc, bc, bok, hok);
        checks++; if (dc != -1 || bc != 0) begin errors++; $display("FAIL midreset_abort: done at %0d busy %0d want none", dc, bc); end
        issue(8'd13, 4'd4);
        track(20, dc, bc, bok, hok);
        checks++; if (dc != 9 || quotient !== 8'd3 || remainder !== 4'd1) begin
            errors++; $display("FAIL midreset_next: got cyc=%0d q=%0d r=%0d want 9 3 1", dc, quotient, remainder);
        end
        @(negedge clk);
    endtask

    // Every 8x4 operand pair, visited in a random permutation with random idle gaps.
    task automatic test_sweep();
        int dc, bc, offset, idx, a, b, eq, er, ec;
        bit bok, hok;
        offset = int'($urandom_range(0, 4095));
        for (int i = 0; i < 4096; i++) begin
            idx = (i * 1237 + offset) % 4096;
            a = idx >> 4;
            b = idx & 15;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            ref_div(a, b, eq, er);
            ec = (b == 0) ? 1 : 9;
            issue(8'(a), 4'(b));
            track(20, dc, bc, bok, hok);
            checks++;
            if (dc != ec || quotient !== 8'(eq) || remainder !== 4'(er) || div_by_zero !== (b == 0) || !bok || !hok) begin
                errors++;
                $display("FAIL sweep_%0d_%0d: got cyc=%0d q=%0d r=%0d dbz=%b busy_ok=%0d hold=%0d want %0d %0d %0d %0d",
                         a, b, dc, quotient, remainder, div_by_zero, bok, hok, ec, eq, er, (b == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_boundary();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
